// File: rtl/i2s_tx_pattern_gen_pkg.sv
// ============================================================================
// Package : i2s_tx_10xe_defines
// Brief   : Shared types and constants for the I2S TX pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_tx_10xe_defines;

    typedef enum logic [2:0] {
        ZERO     = 3'd0,
        ONES     = 3'd1,
        RANDOM   = 3'd2,
        RAMP     = 3'd3,
        WALK_ONE = 3'd4
    } pat_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } patgen_state_e;

    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_LFSR_SEED = 32'h0000_0001;

    // Galois right-shift step; a zero state would lock up, so seeds are nonzero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_pattern_gen_lfsr32.sv
// ============================================================================
// Module  : i2s_tx_lfsr32
// Brief   : 32-bit Galois LFSR with seed load and advance enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_lfsr32
    import i2s_tx_10xe_defines::*;
#(
    parameter logic [31:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (adv_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_pattern_gen.sv
// ============================================================================
// Module  : i2s_tx_pattern_gen
// Brief   : Multi-channel AXI4-Stream audio pattern source for the I2S TX path.
//           Optional inter-frame gap built when I2S_TX_PATGEN_GAP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_pattern_gen
    import i2s_tx_10xe_defines::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          NUM_CH       = 2,
    parameter int          CNT_WIDTH    = 16,
    parameter logic [31:0] LFSR_SEED    = DEFAULT_LFSR_SEED,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [2:0]            mode_i,
    input  logic [CNT_WIDTH-1:0]  num_frames_i,
`ifdef I2S_TX_PATGEN_GAP_EN
    input  logic [7:0]            gap_cycles_i,
`endif
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic [CH_W-1:0]       m_tid_o,
    output logic                  m_tlast_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

    localparam int WP_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
    localparam logic [DATA_WIDTH-1:0] SAMPLE_MASK =
        {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - SAMPLE_WIDTH);

    patgen_state_e         state_q, state_d;
    pat_mode_e             mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  num_frames_q, num_frames_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CH_W-1:0]       tid_q, tid_d;
    logic [WP_W-1:0]       walk_q, walk_d;
    logic [SAMPLE_WIDTH-1:0] ramp_q, ramp_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
`ifdef I2S_TX_PATGEN_GAP_EN
    logic [7:0]            gap_cnt_q, gap_cnt_d;
`endif

    logic                  valid;
    logic                  accept;
    logic                  last_beat;
    logic                  frame_hit;
    logic                  lfsr_load;
    logic                  lfsr_adv;
    logic [31:0]           lfsr_state;
    logic [DATA_WIDTH-1:0] lfsr_ext;
    logic [DATA_WIDTH-1:0] pattern;

    i2s_tx_lfsr32 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_state)
    );

    assign valid     = (state_q == RUN);
    assign accept    = valid && m_tready_i;
    assign last_beat = (tid_q == CH_W'(NUM_CH - 1));
    // Guard against the +1 wrapping to zero once the counter has saturated.
    assign frame_hit = (frame_cnt_q != '1) &&
                       ((frame_cnt_q + CNT_WIDTH'(1)) == num_frames_q);
    assign lfsr_ext  = DATA_WIDTH'(lfsr_state);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        num_frames_d = num_frames_q;
        frame_cnt_d  = frame_cnt_q;
        tid_d        = tid_q;
        walk_d       = walk_q;
        ramp_d       = ramp_q;
        stop_d       = stop_q;
        done_d       = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;
`ifdef I2S_TX_PATGEN_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = RUN;
                    mode_d       = pat_mode_e'(mode_i);
                    num_frames_d = num_frames_i;
                    frame_cnt_d  = '0;
                    tid_d        = '0;
                    walk_d       = '0;
                    ramp_d       = '0;
                    stop_d       = 1'b0;
                    lfsr_load    = 1'b1;
                end
            end
            RUN: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (accept) begin
                    lfsr_adv = 1'b1;
                    walk_d   = (walk_q == WP_W'(SAMPLE_WIDTH - 1)) ? '0 : walk_q + WP_W'(1);
                    tid_d    = last_beat ? '0 : tid_q + CH_W'(1);
                    if (last_beat) begin
                        ramp_d = ramp_q + SAMPLE_WIDTH'(1);
                        stop_d = 1'b0;
                        if (frame_cnt_q != '1) begin
                            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        end
                        if (frame_hit || stop_q || stop_i) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
`ifdef I2S_TX_PATGEN_GAP_EN
                        else if (gap_cycles_i != 8'd0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_cycles_i;
                        end
`endif
                    end
                end
            end
`ifdef I2S_TX_PATGEN_GAP_EN
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= ZERO;
            num_frames_q <= '0;
            frame_cnt_q  <= '0;
            tid_q        <= '0;
            walk_q       <= '0;
            ramp_q       <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef I2S_TX_PATGEN_GAP_EN
            gap_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            num_frames_q <= num_frames_d;
            frame_cnt_q  <= frame_cnt_d;
            tid_q        <= tid_d;
            walk_q       <= walk_d;
            ramp_q       <= ramp_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
`ifdef I2S_TX_PATGEN_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    // Undefined mode encodings fall through to the zero pattern.
    always_comb begin
        pattern = '0;
        case (mode_q)
            ONES:     pattern = SAMPLE_MASK;
            RANDOM:   pattern = lfsr_ext & SAMPLE_MASK;
            RAMP:     pattern = DATA_WIDTH'(ramp_q + SAMPLE_WIDTH'(tid_q));
            WALK_ONE: pattern = DATA_WIDTH'(1) << walk_q;
            default:  pattern = '0;
        endcase
    end

    assign m_tvalid_o  = valid;
    assign m_tdata_o   = valid ? pattern : '0;
    assign m_tid_o     = tid_q;
    assign m_tlast_o   = valid && last_beat;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_pattern_gen.sv
// ============================================================================
// Module  : tb_i2s_tx_pattern_gen
// Brief   : Randomised self-checking bench for i2s_tx_pattern_gen.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx_pattern_gen;

    localparam int          DW   = 32;
    localparam int          SW   = 24;
    localparam int          NCH  = 2;
    localparam int          CW   = 4;
    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          CMAX = (1 << CW) - 1;
`ifdef I2S_TX_PATGEN_GAP_EN
    localparam int          GAP_LEN = 3;
`else
    localparam int          GAP_LEN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [CW-1:0] num_frames = '0;
`ifdef I2S_TX_PATGEN_GAP_EN
    logic [7:0]    gap = 8'(GAP_LEN);
`endif
    logic          tvalid;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic [CHW-1:0] tid;
    logic          tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2s_tx_pattern_gen #(
        .DATA_WIDTH   (DW),
        .SAMPLE_WIDTH (SW),
        .NUM_CH       (NCH),
        .CNT_WIDTH    (CW),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .num_frames_i (num_frames),
`ifdef I2S_TX_PATGEN_GAP_EN
        .gap_cycles_i (gap),
`endif
        .m_tvalid_o   (tvalid),
        .m_tready_i   (tready),
        .m_tdata_o    (tdata),
        .m_tid_o      (tid),
        .m_tlast_o    (tlast),
        .busy_o       (busy),
        .done_o       (done),
        .frame_cnt_o  (frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Expected sample from the pattern rules: frames done, channel, beats done.
    function automatic logic [63:0] exp_sample(input int md, input int frame, input int ch,
                                               input int beat, input logic [31:0] lf);
        logic [63:0] mask;
        mask = (64'd1 << SW) - 64'd1;
        case (md)
            1:       return mask;
            2:       return {32'd0, lf} & mask;
            3:       return (64'(frame) + 64'(ch)) & mask;
            4:       return 64'd1 << (beat % SW);
            default: return 64'd0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // rmode: 0 always ready, 1 alternating 1/0, 2 random.
    task automatic run_job(input int md, input int nfr, input int stop_at, input int rmode,
                           input int rst_at, input bit stop_with_start);
        int          frame = 0;
        int          ch = 0;
        int          beat = 0;
        int          cyc = 0;
        int          gap_left = 0;
        logic [31:0] lf = SEED;
        bit          stop_seen = 0;
        bit          finished = 0;
        bit          rdy;
        bit          exp_valid;

        @(negedge clk);
        mode       = 3'(md);
        num_frames = CW'(nfr);
        start      = 1'b1;
        stop       = stop_with_start;
        tready     = 1'b0;
        @(negedge clk);
        while (!finished) begin
            exp_valid = (gap_left == 0);
            check_eq("tvalid", 64'(tvalid), 64'(exp_valid));
            check_eq("busy", 64'(busy), 64'd1);
            check_eq("done_low", 64'(done), 64'd0);
            check_eq("frame_cnt_run", 64'(frame_cnt), 64'(sat(frame)));
            if (exp_valid) begin
                check_eq("tdata", 64'(tdata), exp_sample(md, frame, ch, beat, lf));
                check_eq("tid", 64'(tid), 64'(ch));
                check_eq("tlast", 64'(tlast), 64'(ch == NCH - 1));
            end

            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            tready = rdy;
            start  = ($urandom_range(0, 7) == 0);
            mode   = 3'($urandom);
            stop   = 1'b0;
            if (stop_at >= 0 && !stop_seen && beat >= stop_at && exp_valid) begin
                stop      = 1'b1;
                stop_seen = 1'b1;
            end

            if (rst_at >= 0 && beat >= rst_at && exp_valid) begin
                rst    = 1'b1;
                tready = 1'b0;
                start  = 1'b0;
                stop   = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_eq("rst_tvalid", 64'(tvalid), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
                check_eq("rst_tid", 64'(tid), 64'd0);
                return;
            end

            if (gap_left > 0) begin
                gap_left--;
            end else if (rdy) begin
                beat++;
                lf = lfsr_step(lf);
                if (ch == NCH - 1) begin
                    ch = 0;
                    frame++;
                    if ((nfr != 0 && frame == nfr) || stop_seen) finished = 1'b1;
                    else gap_left = GAP_LEN;
                end else begin
                    ch++;
                end
            end
            cyc++;
            @(negedge clk);
            if (cyc > 3000 && !finished) begin
                check_eq("timeout", 64'd0, 64'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end

        start  = 1'b0;
        stop   = 1'b0;
        tready = 1'b0;
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("end_busy", 64'(busy), 64'd0);
        check_eq("end_tvalid", 64'(tvalid), 64'd0);
        check_eq("end_frame_cnt", 64'(frame_cnt), 64'(sat(frame)));
        @(negedge clk);
        check_eq("done_clear", 64'(done), 64'd0);
        check_eq("hold_frame_cnt", 64'(frame_cnt), 64'(sat(frame)));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_tvalid", 64'(tvalid), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("reset_tdata", 64'(tdata), 64'd0);
        check_eq("reset_tid", 64'(tid), 64'd0);
        check_eq("reset_tlast", 64'(tlast), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_job(1, 3, -1, 0, -1, 1'b0);   // ONES, three frames, always ready
        run_job(3, 2, -1, 1, -1, 1'b0);   // RAMP with alternating ready
        run_job(2, 4, -1, 2, -1, 1'b0);   // RANDOM from seed
        run_job(4, 0, 5, 0, -1, 1'b0);    // WALK_ONE continuous, stop after beat 5
        run_job(4, 0, 40, 2, -1, 1'b0);   // continuous past counter saturation

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("idle_stop_busy", 64'(busy), 64'd0);
        check_eq("idle_stop_tvalid", 64'(tvalid), 64'd0);

        run_job(1, 2, -1, 2, -1, 1'b0);   // stale stop from IDLE must not end early
        run_job(2, 3, -1, 2, -1, 1'b1);   // start and stop together: stop ignored
        run_job(1, 5, -1, 2, 3, 1'b0);    // reset mid-frame
        run_job(2, 2, -1, 0, -1, 1'b0);   // clean restart after reset

        for (int j = 0; j < 12; j++) begin
            int md;
            int nfr;
            int sa;
            md  = int'($urandom_range(0, 7));
            nfr = int'($urandom_range(0, 6));
            if (nfr == 0) sa = int'($urandom_range(0, 20));
            else          sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            run_job(md, nfr, sa, 2, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
